// File: rtl/dpd_delay_search.sv
// dpd_delay_search: loop-delay estimator (min-L1 sweep) and tx/feedback aligner for DPD
module dpd_delay_search #(
    parameter int W         = 20,
    parameter int DMAX      = 63,
    parameter int NACC      = 256,
    parameter int DEF_DELAY = 41,
    parameter int ACC_W     = W + 1 + $clog2(NACC),
    localparam int DW       = $clog2(DMAX + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [W-1:0] tx_i,
    input  logic signed [W-1:0] tx_q,
    input  logic signed [W-1:0] fb_i,
    input  logic signed [W-1:0] fb_q,
    output logic signed [W-1:0] ref_i,
    output logic signed [W-1:0] ref_q,
    output logic signed [W-1:0] fbo_i,
    output logic signed [W-1:0] fbo_q,
    output logic                busy,
    output logic                done,
    output logic [DW-1:0]       delay_est,
    output logic [ACC_W-1:0]    err_min
);
    localparam int CW = $clog2(NACC);

    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_ACC, S_CMP, S_DONE} state_t;
    state_t state, state_n;

    logic [DMAX:0][2*W-1:0] sr;
    logic signed [W-1:0] fbr_i, fbr_q, fbd_i, fbd_q, tap_i, tap_q;
    logic signed [W:0] di, dq;
    logic [W-1:0] ai, aq;
    logic [W:0] e;
    logic [ACC_W-1:0] acc, best;
    logic [DW-1:0] d, bd;
    logic [CW-1:0] cnt;

    // tx history and one-cycle feedback register; run every cycle, search or not
    always_ff @(posedge clk) begin
        if (reset) begin
            sr    <= '0;
            fbr_i <= '0;
            fbr_q <= '0;
        end else begin
            sr    <= {sr[DMAX-1:0], tx_i, tx_q};
            fbr_i <= fb_i;
            fbr_q <= fb_q;
        end
    end

    assign ref_i = sr[delay_est][2*W-1:W];
    assign ref_q = sr[delay_est][W-1:0];
    assign fbo_i = fbr_i;
    assign fbo_q = fbr_q;

    // differences are W+1 bits so |x| of two W-bit samples never overflows
    assign di = fbd_i - tap_i;
    assign dq = fbd_q - tap_q;
    assign ai = di[W] ? W'(-di) : W'(di);
    assign aq = dq[W] ? W'(-dq) : W'(dq);

    // two-stage error pipeline: tap/feedback pair registered together, then L1 error
    always_ff @(posedge clk) begin
        if (reset) begin
            tap_i <= '0;
            tap_q <= '0;
            fbd_i <= '0;
            fbd_q <= '0;
            e     <= '0;
        end else begin
            tap_i <= sr[d][2*W-1:W];
            tap_q <= sr[d][W-1:0];
            fbd_i <= fbr_i;
            fbd_q <= fbr_q;
            e     <= {1'b0, ai} + {1'b0, aq};
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // next-state logic; FLUSH covers the two pipeline stages after a tap change
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = start ? S_FLUSH : S_IDLE;
            S_FLUSH: state_n = (cnt == CW'(1)) ? S_ACC : S_FLUSH;
            S_ACC:   state_n = (cnt == CW'(NACC - 1)) ? S_CMP : S_ACC;
            S_CMP:   state_n = (d == DW'(DMAX)) ? S_DONE : S_FLUSH;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign busy = state != S_IDLE;
    assign done = state == S_DONE;

    // sweep datapath: accumulate, keep the strictly smaller error, publish on DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            d         <= '0;
            bd        <= '0;
            best      <= '0;
            acc       <= '0;
            delay_est <= DW'(DEF_DELAY);
            err_min   <= '0;
        end else begin
            cnt <= (state_n != state) ? '0 : cnt + 1'b1;
            case (state)
                S_IDLE: if (start) begin
                    d    <= '0;
                    best <= '1;
                end
                S_FLUSH: acc <= '0;
                S_ACC:   acc <= acc + ACC_W'(e);
                S_CMP: begin
                    if (acc < best) begin
                        best <= acc;
                        bd   <= d;
                    end
                    if (d != DW'(DMAX)) d <= d + 1'b1;
                end
                S_DONE: begin
                    delay_est <= bd;
                    err_min   <= best;
                end
                default: ;
            endcase
        end
    end
endmodule
